ft232h_fetch: RTL

//  FPGA-side bus master for the FT232H 245-style synchronous FIFO port; sits directly upstream of ip_ft232h.

---
 rtl/ft232h_fetch.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/ft232h_fetch.sv
// ft232h_fetch: bus master for the FT232H 245-style synchronous FIFO port.
// A 64-bit read request is sent to the device as ADDR_BYTES address bytes,
// least significant byte first. DATA_BYTES data bytes are then read back.
// The result is returned as one little-endian word on a valid/ready channel.
// All logic runs on the FT232H clkout domain.
module ft232h_fetch #(
  parameter int ADDR_BYTES  = 8,
  parameter int DATA_BYTES  = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  inout  logic [7:0]  adbus,
  input  logic        txe_n,
  output logic        wr_n,
  output logic        siwu_n,
  input  logic        rxf_n,
  output logic        oe_n,
  output logic        rd_n
);

  localparam int BCW = $clog2(ADDR_BYTES + 1);
  localparam int SCW = $clog2(DATA_BYTES + 2);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_WAIT_RXF = 3'd2,
    S_READ     = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  state_t         state_q,     state_d;
  logic [63:0]    addr_q,      addr_d;
  logic [BCW-1:0] byte_cnt_q,  byte_cnt_d;
  logic [TCW-1:0] tmo_cnt_q,   tmo_cnt_d;
  logic [SCW-1:0] strb_cnt_q,  strb_cnt_d;
  logic [63:0]    data_q,      data_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_err_q,   rsp_err_d;
  logic           wr_n_q,      wr_n_d;
  logic           oe_n_q,      oe_n_d;
  logic           rd_n_q,      rd_n_d;
  logic           adbus_oe_q,  adbus_oe_d;
  logic           req_ready_q, req_ready_d;
  logic           busy_q,      busy_d;
  logic [2:0]     rd_idx_s;

  // The address byte on the bus is always the bottom of the shift register.
  // The bus is only driven while the address is being written.
  assign adbus     = adbus_oe_q ? addr_q[7:0] : 8'hzz;
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign wr_n      = wr_n_q;
  assign oe_n      = oe_n_q;
  assign rd_n      = rd_n_q;
  assign siwu_n    = 1'b1;

  // Next-state and next-output computation for the fetch sequencer.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    byte_cnt_d  = byte_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    strb_cnt_d  = strb_cnt_q;
    data_d      = data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    wr_n_d      = wr_n_q;
    oe_n_d      = oe_n_q;
    rd_n_d      = rd_n_q;
    adbus_oe_d  = adbus_oe_q;
    req_ready_d = req_ready_q;
    busy_d      = busy_q;
    // Strobe edge n (1-based) samples data byte n-2.
    // strb_cnt_q holds n-1, so the byte index is strb_cnt_q-1.
    rd_idx_s    = 3'(strb_cnt_q - SCW'(1));

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d     = S_ADDR;
          addr_d      = req_addr;
          byte_cnt_d  = {BCW{1'b0}};
          data_d      = 64'h0;
          rsp_err_d   = 1'b0;
          wr_n_d      = 1'b0;
          adbus_oe_d  = 1'b1;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
        end else begin
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end

      S_ADDR: begin
        if (!wr_n_q && !txe_n) begin
          // The device took this byte. Advance to the next one.
          addr_d     = {8'h00, addr_q[63:8]};
          byte_cnt_d = byte_cnt_q + BCW'(1);
          if (byte_cnt_q == BCW'(ADDR_BYTES - 1)) begin
            wr_n_d     = 1'b1;
            adbus_oe_d = 1'b0;
            tmo_cnt_d  = {TCW{1'b0}};
            state_d    = S_WAIT_RXF;
          end else begin
            wr_n_d = 1'b0;
          end
        end else if (txe_n) begin
          // The device FIFO is full. Hold the byte and lift the strobe.
          wr_n_d = 1'b1;
        end else begin
          wr_n_d = 1'b0;
        end
      end

      S_WAIT_RXF: begin
        tmo_cnt_d = tmo_cnt_q + TCW'(1);
        // The first cycle is a bus-release guard, so rxf_n is not honoured
        // at tmo_cnt == 0 and the device is not asked to drive too early.
        if ((tmo_cnt_q != {TCW{1'b0}}) && !rxf_n) begin
          oe_n_d     = 1'b0;
          rd_n_d     = 1'b0;
          strb_cnt_d = {SCW{1'b0}};
          state_d    = S_READ;
        end else if (tmo_cnt_q == TCW'(TIMEOUT_CYC - 1)) begin
          data_d      = 64'h0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          state_d = S_WAIT_RXF;
        end
      end

      S_READ: begin
        if (!rd_n_q && !rxf_n) begin
          strb_cnt_d = strb_cnt_q + SCW'(1);
          if (strb_cnt_q != {SCW{1'b0}}) begin
            data_d[{rd_idx_s, 3'b000} +: 8] = adbus;
          end else begin
            data_d = data_q;
          end
          if (strb_cnt_q == SCW'(DATA_BYTES)) begin
            oe_n_d      = 1'b1;
            rd_n_d      = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end else begin
            oe_n_d = 1'b0;
            rd_n_d = 1'b0;
          end
        end else if (rxf_n) begin
          // The device ran dry mid-burst. Pause the strobes.
          oe_n_d = 1'b1;
          rd_n_d = 1'b1;
        end else begin
          oe_n_d = 1'b0;
          rd_n_d = 1'b0;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        wr_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        rd_n_d      = 1'b1;
        adbus_oe_d  = 1'b0;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and registered-output flops. Reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= 64'h0;
      byte_cnt_q  <= {BCW{1'b0}};
      tmo_cnt_q   <= {TCW{1'b0}};
      strb_cnt_q  <= {SCW{1'b0}};
      data_q      <= 64'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      wr_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      adbus_oe_q  <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      byte_cnt_q  <= byte_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      strb_cnt_q  <= strb_cnt_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      wr_n_q      <= wr_n_d;
      oe_n_q      <= oe_n_d;
      rd_n_q      <= rd_n_d;
      adbus_oe_q  <= adbus_oe_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

endmodule
